// File: rtl/vram_arb_pkg.sv
// Shared widths and return-owner type for the VRAM arbiter.
package vram_arb_pkg;

    localparam int unsigned VRAM_AW = 16;
    localparam int unsigned VRAM_DW = 16;
    localparam int unsigned VRAM_MW = 4;

    typedef enum logic [1:0] {
        OWN_VGEN,
        OWN_REGS,
        OWN_BLIT
    } vram_owner_t;

endpackage

// File: rtl/vram_arb_if.sv
// Requester, VRAM-port and stall-statistics signals of the VRAM arbiter.
interface vram_arb_if #(
    parameter int unsigned STALL_W = 16
);
    import vram_arb_pkg::*;

    logic               vgen_sel_i;
    logic [VRAM_AW-1:0] vgen_addr_i;
    logic               vgen_rd_valid_o;

    logic               regs_sel_i;
    logic               regs_wr_i;
    logic [VRAM_MW-1:0] regs_mask_i;
    logic [VRAM_AW-1:0] regs_addr_i;
    logic [VRAM_DW-1:0] regs_data_i;
    logic               regs_ack_o;
    logic               regs_rd_valid_o;

    logic               blit_sel_i;
    logic               blit_wr_i;
    logic [VRAM_MW-1:0] blit_mask_i;
    logic [VRAM_AW-1:0] blit_addr_i;
    logic [VRAM_DW-1:0] blit_data_i;
    logic               blit_ack_o;
    logic               blit_rd_valid_o;

    logic [VRAM_DW-1:0] rd_data_o;

    logic               vram_sel_o;
    logic               vram_wr_o;
    logic [VRAM_MW-1:0] vram_mask_o;
    logic [VRAM_AW-1:0] vram_addr_o;
    logic [VRAM_DW-1:0] vram_data_o;
    logic [VRAM_DW-1:0] vram_data_i;

    logic               stall_clr_i;
    logic [STALL_W-1:0] regs_stall_o;
    logic [STALL_W-1:0] blit_stall_o;

    modport slave (
        input  vgen_sel_i, vgen_addr_i,
        input  regs_sel_i, regs_wr_i, regs_mask_i, regs_addr_i, regs_data_i,
        input  blit_sel_i, blit_wr_i, blit_mask_i, blit_addr_i, blit_data_i,
        input  vram_data_i, stall_clr_i,
        output vgen_rd_valid_o, regs_ack_o, regs_rd_valid_o, blit_ack_o, blit_rd_valid_o,
        output rd_data_o, vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_o,
        output regs_stall_o, blit_stall_o
    );

    modport master (
        output vgen_sel_i, vgen_addr_i,
        output regs_sel_i, regs_wr_i, regs_mask_i, regs_addr_i, regs_data_i,
        output blit_sel_i, blit_wr_i, blit_mask_i, blit_addr_i, blit_data_i,
        output vram_data_i, stall_clr_i,
        input  vgen_rd_valid_o, regs_ack_o, regs_rd_valid_o, blit_ack_o, blit_rd_valid_o,
        input  rd_data_o, vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_o,
        input  regs_stall_o, blit_stall_o
    );

endinterface

// File: rtl/vram_arb.sv
// VRAM arbiter: vgen has absolute priority, regs and blit share the rest round-robin.
// Stall counters are built only when VRAM_ARB_STATS_EN is defined.
module vram_arb
    import vram_arb_pkg::*;
#(
    parameter int unsigned STALL_W = 16
) (
    input  logic      clk,
    input  logic      reset_n,
    vram_arb_if.slave bus
);

    logic        gnt_vgen;
    logic        gnt_regs;
    logic        gnt_blit;
    logic        last_blit;
    logic        rd_valid;
    logic        rd_valid_next;
    vram_owner_t rd_owner;
    vram_owner_t rd_owner_next;

    // On a regs/blit tie the requester that did not win last time goes first.
    always_comb begin
        gnt_vgen = bus.vgen_sel_i;
        gnt_regs = !bus.vgen_sel_i && bus.regs_sel_i && (!bus.blit_sel_i || last_blit);
        gnt_blit = !bus.vgen_sel_i && bus.blit_sel_i && (!bus.regs_sel_i || !last_blit);
    end

    always_comb begin
        bus.vram_sel_o  = 1'b0;
        bus.vram_wr_o   = 1'b0;
        bus.vram_mask_o = '0;
        bus.vram_addr_o = '0;
        bus.vram_data_o = '0;
        if (gnt_vgen) begin
            bus.vram_sel_o  = 1'b1;
            bus.vram_addr_o = bus.vgen_addr_i;
        end else if (gnt_regs) begin
            bus.vram_sel_o  = 1'b1;
            bus.vram_wr_o   = bus.regs_wr_i;
            bus.vram_mask_o = bus.regs_mask_i;
            bus.vram_addr_o = bus.regs_addr_i;
            bus.vram_data_o = bus.regs_data_i;
        end else if (gnt_blit) begin
            bus.vram_sel_o  = 1'b1;
            bus.vram_wr_o   = bus.blit_wr_i;
            bus.vram_mask_o = bus.blit_mask_i;
            bus.vram_addr_o = bus.blit_addr_i;
            bus.vram_data_o = bus.blit_data_i;
        end
    end

    always_comb begin
        rd_valid_next = 1'b0;
        rd_owner_next = rd_owner;
        if (gnt_vgen) begin
            rd_valid_next = 1'b1;
            rd_owner_next = OWN_VGEN;
        end else if (gnt_regs && !bus.regs_wr_i) begin
            rd_valid_next = 1'b1;
            rd_owner_next = OWN_REGS;
        end else if (gnt_blit && !bus.blit_wr_i) begin
            rd_valid_next = 1'b1;
            rd_owner_next = OWN_BLIT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid  <= 1'b0;
            rd_owner  <= OWN_VGEN;
            last_blit <= 1'b1;
        end else begin
            rd_valid <= rd_valid_next;
            rd_owner <= rd_owner_next;
            if (gnt_regs) begin
                last_blit <= 1'b0;
            end else if (gnt_blit) begin
                last_blit <= 1'b1;
            end
        end
    end

    assign bus.regs_ack_o      = gnt_regs;
    assign bus.blit_ack_o      = gnt_blit;
    assign bus.vgen_rd_valid_o = rd_valid && (rd_owner == OWN_VGEN);
    assign bus.regs_rd_valid_o = rd_valid && (rd_owner == OWN_REGS);
    assign bus.blit_rd_valid_o = rd_valid && (rd_owner == OWN_BLIT);
    assign bus.rd_data_o       = bus.vram_data_i;

`ifdef VRAM_ARB_STATS_EN
    logic [STALL_W-1:0] regs_stall;
    logic [STALL_W-1:0] blit_stall;

    // Clear wins over counting; counts saturate at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_stall <= '0;
            blit_stall <= '0;
        end else if (bus.stall_clr_i) begin
            regs_stall <= '0;
            blit_stall <= '0;
        end else begin
            if (bus.regs_sel_i && !gnt_regs && (regs_stall != '1)) begin
                regs_stall <= regs_stall + STALL_W'(1);
            end
            if (bus.blit_sel_i && !gnt_blit && (blit_stall != '1)) begin
                blit_stall <= blit_stall + STALL_W'(1);
            end
        end
    end

    assign bus.regs_stall_o = regs_stall;
    assign bus.blit_stall_o = blit_stall;
`else
    logic unused_stall_clr;
    assign unused_stall_clr  = bus.stall_clr_i;
    assign bus.regs_stall_o  = '0;
    assign bus.blit_stall_o  = '0;
`endif

`ifndef SYNTHESIS
    a_regs_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (bus.regs_sel_i && !bus.regs_ack_o) |=> bus.regs_sel_i);
    a_blit_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (bus.blit_sel_i && !bus.blit_ack_o) |=> bus.blit_sel_i);
    a_one_ack: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0({bus.regs_ack_o, bus.blit_ack_o}));
    a_one_valid: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0({bus.vgen_rd_valid_o, bus.regs_rd_valid_o, bus.blit_rd_valid_o}));
`endif

endmodule

// File: tb/tb_vram_arb.sv
// Self-checking bench for vram_arb: vector table, directed corner cases and a
// randomized run against a request-level reference model. Honours VRAM_ARB_STATS_EN.
module tb_vram_arb;
    import vram_arb_pkg::*;

    localparam int unsigned SW = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vram_arb_if #(.STALL_W(SW)) bus ();
    vram_arb #(.STALL_W(SW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int n_pass = 0;
    int n_total = 0;

    bit [15:0] env_mem [65536] = '{default: 16'h0000};
    bit [15:0] ref_mem [65536] = '{default: 16'h0000};

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic [3:0] mask);
        logic [15:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (mask[i]) r[i*4 +: 4] = nw[i*4 +: 4];
        return r;
    endfunction

    // Behavioural VRAM: write on the sel edge, read data appears one cycle later.
    always @(posedge clk) begin
        if (bus.vram_sel_o) begin
            if (bus.vram_wr_o)
                env_mem[bus.vram_addr_o] <= merge(env_mem[bus.vram_addr_o], bus.vram_data_o,
                                                  bus.vram_mask_o);
            else
                bus.vram_data_i <= env_mem[bus.vram_addr_o];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [2:0] rv_vec();
        return {bus.blit_rd_valid_o, bus.regs_rd_valid_o, bus.vgen_rd_valid_o};
    endfunction

    task automatic idle();
        bus.vgen_sel_i = 1'b0; bus.vgen_addr_i = '0;
        bus.regs_sel_i = 1'b0; bus.regs_wr_i = 1'b0; bus.regs_mask_i = '0;
        bus.regs_addr_i = '0; bus.regs_data_i = '0;
        bus.blit_sel_i = 1'b0; bus.blit_wr_i = 1'b0; bus.blit_mask_i = '0;
        bus.blit_addr_i = '0; bus.blit_data_i = '0;
        bus.stall_clr_i = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  in;     // {vgen, regs, regs_wr, blit}
        logic [3:0]  o;      // {regs_ack, blit_ack, vram_sel, vram_wr}
        logic [15:0] addr;
        logic [2:0]  rv;     // {blit, regs, vgen} rd_valid from the previous row
        logic        chk_mask;
        logic [3:0]  mask;
    } vec_t;

    vec_t tbl [8];

    typedef struct {
        bit          pend;
        logic        wr;
        logic [3:0]  mask;
        logic [15:0] addr;
        logic [15:0] data;
    } req_t;

    initial begin
        req_t        rq, bq;
        bit          v;
        logic [15:0] va;
        int          win, last_winner, exp_owner, nxt_owner;
        logic [15:0] exp_rdata, nxt_rdata;
        logic [2:0]  exp_rv;
        logic        exp_wr;
        logic [3:0]  exp_mask;
        logic [15:0] exp_addr, exp_data;

        tbl[0] = '{4'b0101, 4'b1010, 16'h1000, 3'b000, 1'b0, 4'h0};
        tbl[1] = '{4'b0101, 4'b0110, 16'h2001, 3'b010, 1'b0, 4'h0};
        tbl[2] = '{4'b0101, 4'b1010, 16'h1002, 3'b100, 1'b0, 4'h0};
        tbl[3] = '{4'b1101, 4'b0010, 16'h0103, 3'b010, 1'b1, 4'h0};
        tbl[4] = '{4'b0101, 4'b0110, 16'h2004, 3'b001, 1'b0, 4'h0};
        tbl[5] = '{4'b0110, 4'b1011, 16'h1005, 3'b100, 1'b1, 4'hF};
        tbl[6] = '{4'b0001, 4'b0110, 16'h2006, 3'b000, 1'b0, 4'h0};
        tbl[7] = '{4'b0000, 4'b0000, 16'h0000, 3'b100, 1'b0, 4'h0};

        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset rd_valid", 32'(rv_vec()), 32'h0);
        check("reset regs_stall", 32'(bus.regs_stall_o), 32'h0);
        check("reset blit_stall", 32'(bus.blit_stall_o), 32'h0);
        reset_n = 1'b1;

        // Table: starts straight after reset so the first tie must go to regs.
        for (int i = 0; i < 8; i++) begin
            bus.vgen_sel_i  = tbl[i].in[3];
            bus.vgen_addr_i = 16'h0100 + 16'(i);
            bus.regs_sel_i  = tbl[i].in[2];
            bus.regs_wr_i   = tbl[i].in[1];
            bus.regs_mask_i = 4'hF;
            bus.regs_addr_i = 16'h1000 + 16'(i);
            bus.regs_data_i = 16'hC000 + 16'(i);
            bus.blit_sel_i  = tbl[i].in[0];
            bus.blit_wr_i   = 1'b0;
            bus.blit_mask_i = 4'hF;
            bus.blit_addr_i = 16'h2000 + 16'(i);
            @(negedge clk);
            check($sformatf("tbl%0d ack/sel/wr", i),
                  32'({bus.regs_ack_o, bus.blit_ack_o, bus.vram_sel_o, bus.vram_wr_o}),
                  32'(tbl[i].o));
            if (tbl[i].o[1]) check($sformatf("tbl%0d addr", i), 32'(bus.vram_addr_o),
                                   32'(tbl[i].addr));
            if (tbl[i].chk_mask) check($sformatf("tbl%0d mask", i), 32'(bus.vram_mask_o),
                                       32'(tbl[i].mask));
            if (tbl[i].o[0]) check($sformatf("tbl%0d wdata", i), 32'(bus.vram_data_o),
                                   32'(16'hC000 + 16'(i)));
            check($sformatf("tbl%0d rd_valid", i), 32'(rv_vec()), 32'(tbl[i].rv));
            next_cycle();
        end
        idle();
        next_cycle();

        // Preload 0x1234, then a lone regs read of it.
        bus.regs_sel_i = 1'b1; bus.regs_wr_i = 1'b1; bus.regs_mask_i = 4'hF;
        bus.regs_addr_i = 16'h1234; bus.regs_data_i = 16'h5A5A;
        next_cycle();
        bus.regs_wr_i = 1'b0;
        @(negedge clk);
        check("rd1234 ack", 32'(bus.regs_ack_o), 32'h1);
        check("rd1234 addr", 32'(bus.vram_addr_o), 32'h1234);
        check("rd1234 wr", 32'(bus.vram_wr_o), 32'h0);
        next_cycle();
        idle();
        @(negedge clk);
        check("rd1234 valid", 32'(rv_vec()), 32'h2);
        check("rd1234 data", 32'(bus.rd_data_o), 32'h5A5A);
        next_cycle();

        // vgen collides with a regs write; the write waits one cycle intact.
        bus.vgen_sel_i = 1'b1; bus.vgen_addr_i = 16'h0100;
        bus.regs_sel_i = 1'b1; bus.regs_wr_i = 1'b1; bus.regs_mask_i = 4'b1010;
        bus.regs_addr_i = 16'h0200; bus.regs_data_i = 16'h1357;
        @(negedge clk);
        check("vgen win regs_ack", 32'(bus.regs_ack_o), 32'h0);
        check("vgen win addr", 32'(bus.vram_addr_o), 32'h0100);
        check("vgen win wr/mask", 32'({bus.vram_wr_o, bus.vram_mask_o}), 32'h0);
        next_cycle();
        bus.vgen_sel_i = 1'b0;
        @(negedge clk);
        check("held wr ack", 32'(bus.regs_ack_o), 32'h1);
        check("held wr fields", {bus.vram_wr_o, 3'b0, bus.vram_mask_o, bus.vram_addr_o},
              {1'b1, 3'b0, 4'b1010, 16'h0200});
        check("held wr data", 32'(bus.vram_data_o), 32'h1357);
        check("vgen valid", 32'(rv_vec()), 32'h1);
        next_cycle();
        idle();
        @(negedge clk);
        check("write no valid", 32'(rv_vec()), 32'h0);
        next_cycle();

        // Nibble-masked write then readback.
        bus.regs_sel_i = 1'b1; bus.regs_wr_i = 1'b1; bus.regs_mask_i = 4'b0101;
        bus.regs_addr_i = 16'h0040; bus.regs_data_i = 16'hABCD;
        next_cycle();
        bus.regs_wr_i = 1'b0;
        next_cycle();
        idle();
        @(negedge clk);
        check("mask readback", 32'(bus.rd_data_o), 32'h0B0D);
        check("mask readback valid", 32'(rv_vec()), 32'h2);
        next_cycle();

        // Blit read granted, reset the following cycle: its return must vanish.
        bus.blit_sel_i = 1'b1; bus.blit_addr_i = 16'h0050;
        @(negedge clk);
        check("pre-reset blit ack", 32'(bus.blit_ack_o), 32'h1);
        next_cycle();
        bus.blit_sel_i = 1'b0;
        bus.regs_sel_i = 1'b1; bus.regs_addr_i = 16'h0060;
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("in-reset rd_valid", 32'(rv_vec()), 32'h0);
        next_cycle();
        bus.regs_addr_i = 16'h0070;
        bus.blit_sel_i = 1'b1; bus.blit_addr_i = 16'h0080;
        reset_n = 1'b1;
        @(negedge clk);
        check("post-reset no valid", 32'(rv_vec()), 32'h0);
        check("post-reset tie", 32'({bus.regs_ack_o, bus.blit_ack_o}), 32'h2);
        next_cycle();
        bus.regs_sel_i = 1'b0;
        @(negedge clk);
        check("post-reset blit next", 32'(bus.blit_ack_o), 32'h1);
        check("post-reset regs valid", 32'(rv_vec()), 32'h2);
        next_cycle();

        // Randomized run against a request-level model.
        do_reset();
        rq = '{default: '0};
        bq = '{default: '0};
        last_winner = 3;  // as if blit had just won, so regs takes the first tie
        exp_owner = 0;
        exp_rdata = '0;
        for (int c = 0; c < 400; c++) begin
            v  = ($urandom_range(0, 3) == 0);
            va = 16'hF000 | 16'($urandom_range(0, 15));
            if (!rq.pend && $urandom_range(0, 1) == 1)
                rq = '{1'b1, 1'($urandom), 4'($urandom), 16'hF000 | 16'($urandom_range(0, 15)),
                       16'($urandom)};
            if (!bq.pend && $urandom_range(0, 1) == 1)
                bq = '{1'b1, 1'($urandom), 4'($urandom), 16'hF000 | 16'($urandom_range(0, 15)),
                       16'($urandom)};
            bus.vgen_sel_i = v; bus.vgen_addr_i = va;
            bus.regs_sel_i = rq.pend; bus.regs_wr_i = rq.wr; bus.regs_mask_i = rq.mask;
            bus.regs_addr_i = rq.addr; bus.regs_data_i = rq.data;
            bus.blit_sel_i = bq.pend; bus.blit_wr_i = bq.wr; bus.blit_mask_i = bq.mask;
            bus.blit_addr_i = bq.addr; bus.blit_data_i = bq.data;

            if (v) win = 1;
            else if (rq.pend && bq.pend) win = (last_winner == 2) ? 3 : 2;
            else if (rq.pend) win = 2;
            else if (bq.pend) win = 3;
            else win = 0;

            @(negedge clk);
            check("rnd ack", 32'({bus.regs_ack_o, bus.blit_ack_o}),
                  32'({win == 2, win == 3}));
            check("rnd sel", 32'(bus.vram_sel_o), 32'(win != 0));
            if (win != 0) begin
                exp_wr = 1'b0; exp_mask = '0; exp_addr = va; exp_data = '0;
                if (win == 2) begin
                    exp_wr = rq.wr; exp_addr = rq.addr;
                    if (rq.wr) begin exp_mask = rq.mask; exp_data = rq.data; end
                end else if (win == 3) begin
                    exp_wr = bq.wr; exp_addr = bq.addr;
                    if (bq.wr) begin exp_mask = bq.mask; exp_data = bq.data; end
                end
                check("rnd wr/addr", {15'b0, bus.vram_wr_o, bus.vram_addr_o},
                      {15'b0, exp_wr, exp_addr});
                if (win == 1 || exp_wr) check("rnd mask", 32'(bus.vram_mask_o), 32'(exp_mask));
                if (exp_wr) check("rnd wdata", 32'(bus.vram_data_o), 32'(exp_data));
            end
            case (exp_owner)
                1: exp_rv = 3'b001;
                2: exp_rv = 3'b010;
                3: exp_rv = 3'b100;
                default: exp_rv = 3'b000;
            endcase
            check("rnd rd_valid", 32'(rv_vec()), 32'(exp_rv));
            if (exp_owner != 0) check("rnd rd_data", 32'(bus.rd_data_o), 32'(exp_rdata));

            nxt_owner = 0;
            nxt_rdata = '0;
            if (win == 1) begin
                nxt_owner = 1; nxt_rdata = ref_mem[va];
            end else if (win == 2) begin
                if (rq.wr) ref_mem[rq.addr] = merge(ref_mem[rq.addr], rq.data, rq.mask);
                else begin nxt_owner = 2; nxt_rdata = ref_mem[rq.addr]; end
                rq.pend = 1'b0;
                last_winner = 2;
            end else if (win == 3) begin
                if (bq.wr) ref_mem[bq.addr] = merge(ref_mem[bq.addr], bq.data, bq.mask);
                else begin nxt_owner = 3; nxt_rdata = ref_mem[bq.addr]; end
                bq.pend = 1'b0;
                last_winner = 3;
            end
            exp_owner = nxt_owner;
            exp_rdata = nxt_rdata;
            next_cycle();
        end
        idle();
        next_cycle();

`ifdef VRAM_ARB_STATS_EN
        do_reset();
        bus.regs_sel_i = 1'b1; bus.regs_addr_i = 16'h0300;
        bus.vgen_sel_i = 1'b1;
        repeat (5) next_cycle();
        bus.vgen_sel_i = 1'b0;
        @(negedge clk);
        check("stall count 5", 32'(bus.regs_stall_o), 32'd5);
        check("blit stall idle", 32'(bus.blit_stall_o), 32'd0);
        next_cycle();
        idle();
        bus.stall_clr_i = 1'b1;
        next_cycle();
        bus.stall_clr_i = 1'b0;
        @(negedge clk);
        check("stall clear", 32'(bus.regs_stall_o), 32'd0);
        next_cycle();
        bus.regs_sel_i = 1'b1; bus.vgen_sel_i = 1'b1;
        repeat (65540) next_cycle();
        @(negedge clk);
        check("stall saturate", 32'(bus.regs_stall_o), 32'hFFFF);
        next_cycle();
        bus.stall_clr_i = 1'b1;
        next_cycle();
        bus.stall_clr_i = 1'b0;
        @(negedge clk);
        check("clear beats count", 32'(bus.regs_stall_o), 32'd0);
        next_cycle();
        bus.vgen_sel_i = 1'b0;
        next_cycle();
        idle();
        next_cycle();
`else
        bus.stall_clr_i = 1'b1;
        bus.regs_sel_i = 1'b1; bus.vgen_sel_i = 1'b1;
        next_cycle();
        bus.stall_clr_i = 1'b0;
        next_cycle();
        bus.vgen_sel_i = 1'b0;
        @(negedge clk);
        check("stats off regs", 32'(bus.regs_stall_o), 32'd0);
        check("stats off blit", 32'(bus.blit_stall_o), 32'd0);
        next_cycle();
        idle();
        next_cycle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
